matrix_loader: RTL and testbench

Upstream input stage for the 8x8 signed matrix multiplier. It accepts a row-major byte stream over a valid/ready handshake and writes matrix A (first 64 bytes) and then matrix B (next 64 bytes) into the multiplier's input RAMs in the column-major layout the multiplier expects. After a correctly framed load, it pulses the multiplier's `start` for one cycle. It then waits for the multiplier's `done` and reports completion.

---
 rtl/matrix_loader_if.sv | 33 +++
 rtl/matrix_loader.sv | 146 ++++++++++++++
 tb/tb_matrix_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_loader_if.sv
// Signal bundle between the matrix loader, its upstream byte stream,
// the multiplier's input RAMs and the multiplier start/done handshake.
interface matrix_loader_if #(
   parameter int DW = 8,
   parameter int AW = 6
);
   logic          load_req;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          in_ready;
   logic          wrA;
   logic          wrB;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          start;
   logic          done;
   logic          busy;
   logic          complete;
   logic          err;

   // Loader side
   modport slave (
      input  load_req, in_valid, in_data, in_last, done,
      output in_ready, wrA, wrB, waddr, wdata, start, busy, complete, err
   );

   // Environment side (stream source, RAMs, multiplier)
   modport master (
      output load_req, in_valid, in_data, in_last, done,
      input  in_ready, wrA, wrB, waddr, wdata, start, busy, complete, err
   );
endinterface

// File: rtl/matrix_loader.sv
// Matrix loader: takes a 128-beat row-major stream (A then B), writes each
// matrix column-major into the multiplier RAMs, pulses start after a
// correctly framed load and reports the multiplier's done rising edge.
module matrix_loader #(
   parameter int DW  = 8,
   parameter int DIM = 8,
   parameter int AW  = 6
) (
   input  logic           clk,
   input  logic           reset,
   matrix_loader_if.slave bus
);
   // AW is split evenly into row and column fields (DIM = 2**(AW/2)).
   localparam int LG = AW / 2;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LAST_A = CW'(DIM * DIM - 1);
   localparam logic [CW-1:0] LAST_B = CW'(2 * DIM * DIM - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_START,
      S_WAIT_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          start_q, start_d;
   logic          complete_q, complete_d;
   logic          wra_q, wra_d;
   logic          wrb_q, wrb_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          done_q;
   logic          in_ready;
   logic          accept;

   assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign accept   = bus.in_valid && in_ready;

   assign bus.in_ready = in_ready;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.err      = err_q;
   assign bus.start    = start_q;
   assign bus.complete = complete_q;
   assign bus.wrA      = wra_q;
   assign bus.wrB      = wrb_q;
   assign bus.waddr    = waddr_q;
   assign bus.wdata    = wdata_q;

   // Next state, beat counter, framing check and registered write port.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      start_d    = 1'b0;
      complete_d = 1'b0;
      wra_d      = 1'b0;
      wrb_d      = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.load_req) begin
               state_d = S_LOAD_A;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end

         S_LOAD_A, S_LOAD_B: begin
            if (accept) begin
               // Beat index low bits are {row, col}; swapping the fields
               // gives the column-major address row + DIM*col.
               wra_d   = ~cnt_q[AW];
               wrb_d   = cnt_q[AW];
               waddr_d = {cnt_q[LG-1:0], cnt_q[AW-1:LG]};
               wdata_d = bus.in_data;
               cnt_d   = cnt_q + 1'b1;

               if (cnt_q == LAST_B) begin
                  if (bus.in_last) begin
                     state_d = S_START;
                     start_d = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     err_d   = 1'b1;
                  end
               end else if (bus.in_last) begin
                  // Early last: the beat is still written, frame dropped.
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end else if (cnt_q == LAST_A) begin
                  state_d = S_LOAD_B;
               end
            end
         end

         S_START: begin
            state_d = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            // Only a fresh low-to-high edge counts; a stale high done waits.
            if (bus.done && !done_q) begin
               state_d    = S_IDLE;
               complete_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         complete_q <= 1'b0;
         wra_q      <= 1'b0;
         wrb_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         start_q    <= start_d;
         complete_q <= complete_d;
         wra_q      <= wra_d;
         wrb_q      <= wrb_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         done_q     <= bus.done;
      end
   end
endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: randomized valid gaps against a beat-level
// reference model, plus directed framing, done-edge and reset scenarios.
module tb_matrix_loader;
   localparam int DW  = 8;
   localparam int DIM = 8;
   localparam int AW  = 6;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_START = 2;
   localparam int M_WAIT  = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matrix_loader_if #(.DW(DW), .AW(AW)) bus ();
   matrix_loader #(.DW(DW), .DIM(DIM), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model: phase for the current cycle, beats taken so far,
   // and the outputs expected in the current cycle
   int            m_phase;
   int            m_beat;
   logic          m_err;
   logic          m_done_prev;
   logic          e_wra, e_wrb, e_start, e_comp;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   int            acc_cyc, start_cyc;

   logic [DW-1:0] fdata [128];
   logic [DW-1:0] cap_a [64];
   logic [DW-1:0] cap_b [64];
   logic [AW-1:0] log_addr [128];
   logic [DW-1:0] log_data [128];
   int n_wr, n_wra, n_wrb, n_start, n_comp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = M_IDLE; m_beat = 0; m_err = 1'b0; m_done_prev = 1'b0;
      e_wra = 1'b0; e_wrb = 1'b0; e_start = 1'b0; e_comp = 1'b0;
      e_addr = '0; e_data = '0;
   endtask

   // advance the model by one clock using the inputs currently driven
   task automatic model_step();
      int b;
      e_wra = 1'b0; e_wrb = 1'b0; e_start = 1'b0; e_comp = 1'b0;
      if (reset) begin
         model_reset();
         return;
      end
      case (m_phase)
         M_IDLE: if (bus.load_req) begin
            m_phase = M_LOAD; m_beat = 0; m_err = 1'b0;
         end
         M_LOAD: if (bus.in_valid) begin
            b      = m_beat % 64;
            e_addr = AW'((b / 8) + 8 * (b % 8));
            e_data = bus.in_data;
            if (m_beat < 64) e_wra = 1'b1; else e_wrb = 1'b1;
            if (m_beat == 127) begin
               acc_cyc = cyc;
               if (bus.in_last) begin m_phase = M_START; e_start = 1'b1; end
               else begin m_phase = M_IDLE; m_err = 1'b1; end
            end else if (bus.in_last) begin
               m_phase = M_IDLE; m_err = 1'b1;
            end
            m_beat++;
         end
         M_START: m_phase = M_WAIT;
         M_WAIT: if (bus.done && !m_done_prev) begin
            m_phase = M_IDLE; e_comp = 1'b1;
         end
         default: m_phase = M_IDLE;
      endcase
      m_done_prev = bus.done;
   endtask

   function automatic logic [31:0] expv();
      logic ew;
      ew = e_wra | e_wrb;
      return {11'b0, e_wra, e_wrb, ew ? e_addr : AW'(0), ew ? e_data : DW'(0),
              e_start, e_comp, (m_phase != M_IDLE), m_err, (m_phase == M_LOAD)};
   endfunction

   // one clock: check outputs mid-cycle, log writes, step the model
   task automatic tick();
      logic [31:0] obs;
      logic ew;
      @(negedge clk);
      ew  = e_wra | e_wrb;
      obs = {11'b0, bus.wrA, bus.wrB, ew ? bus.waddr : AW'(0), ew ? bus.wdata : DW'(0),
             bus.start, bus.complete, bus.busy, bus.err, bus.in_ready};
      chk($sformatf("cyc%0d", cyc), obs, expv());
      if (bus.wrA) begin cap_a[bus.waddr] = bus.wdata; n_wra++; end
      if (bus.wrB) begin cap_b[bus.waddr] = bus.wdata; n_wrb++; end
      if (bus.wrA || bus.wrB) begin
         if (n_wr < 128) begin log_addr[n_wr] = bus.waddr; log_data[n_wr] = bus.wdata; end
         n_wr++;
      end
      if (bus.start) begin n_start++; start_cyc = cyc; end
      if (bus.complete) n_comp++;
      model_step();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {11'b0, bus.wrA, bus.wrB, bus.waddr, bus.wdata, bus.start, bus.complete,
                bus.busy, bus.err, bus.in_ready}, 32'd0);
   endtask

   task automatic clear_logs();
      n_wr = 0; n_wra = 0; n_wrb = 0; n_start = 0; n_comp = 0;
      for (int i = 0; i < 64; i++) begin cap_a[i] = 'x; cap_b[i] = 'x; end
   endtask

   task automatic pulse_load();
      bus.load_req = 1'b1;
      tick();
      bus.load_req = 1'b0;
   endtask

   // stream beats while the model is loading; last_at<0 means never, rst_at
   // is the beat count at which reset is pulsed mid-cycle
   task automatic run_frame(input int last_at, input int gap_pct, input int rst_at);
      int guard;
      guard = 0;
      while (m_phase == M_LOAD && guard < 2000) begin
         if (m_beat == rst_at) begin
            bus.in_valid = 1'b0;
            reset = 1'b1;
            #1;
            chk_zero("async_rst");
            model_reset();
            tick();
            reset = 1'b0;
            return;
         end
         bus.in_valid = ($urandom_range(99) >= gap_pct);
         bus.in_data  = fdata[m_beat];
         bus.in_last  = (m_beat == last_at);
         tick();
         guard++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (guard >= 2000) chk("frame_timeout", 32'd1, 32'd0);
   endtask

   // RAM images must hold element (r,c) at r+8c
   task automatic ram_chk(input string tag);
      for (int b = 0; b < 64; b++) begin
         chk({tag, "_A"}, cap_a[(b % 8) * 8 + b / 8], fdata[b]);
         chk({tag, "_B"}, cap_b[(b % 8) * 8 + b / 8], fdata[64 + b]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      bus.load_req = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      bus.in_last = 1'b0; bus.done = 1'b0;
      for (int i = 0; i < 128; i++) fdata[i] = (i < 64) ? DW'(i) : DW'(64 - i);
      model_reset();
      clear_logs();

      // reset state
      #2 reset = 1'b1;
      #1 chk_zero("reset");
      @(posedge clk); #1;
      tick();
      reset = 1'b0;
      tick();

      // full gap-free load
      clear_logs();
      pulse_load();
      run_frame(127, 0, -1);
      tick(); tick();
      chk("t1_nwrA", n_wra, 64);
      chk("t1_nwrB", n_wrb, 64);
      chk("t1_nstart", n_start, 1);
      chk("t1_start_lat", start_cyc - acc_cyc, 1);
      chk("t1_addr_b9", log_addr[9], 9);
      chk("t1_addr_b10", log_addr[10], 17);
      chk("t1_addr_B1", log_addr[65], 8);
      chk("t1_data_B1", log_data[65], 8'hFF);
      ram_chk("t1_ram");
      repeat (3) tick();
      bus.done = 1'b1;
      tick(); tick();
      chk("t1_ncomp", n_comp, 1);
      chk("t1_busy", bus.busy, 0);
      bus.done = 1'b0;
      tick();

      // random valid gaps
      clear_logs();
      pulse_load();
      run_frame(127, 30, -1);
      tick(); tick();
      chk("t2_nwrA", n_wra, 64);
      chk("t2_nwrB", n_wrb, 64);
      chk("t2_nstart", n_start, 1);
      ram_chk("t2_ram");
      bus.done = 1'b1;
      tick(); tick();
      chk("t2_ncomp", n_comp, 1);
      bus.done = 1'b0;
      tick();

      // in_last on beat 40
      clear_logs();
      pulse_load();
      run_frame(40, 0, -1);
      tick();
      chk("t3_err", bus.err, 1);
      chk("t3_busy", bus.busy, 0);
      chk("t3_nwrA", n_wra, 41);
      chk("t3_b40", cap_a[5], fdata[40]);
      repeat (3) tick();
      chk("t3_nstart", n_start, 0);
      pulse_load();
      chk("t3_err_clr", bus.err, 0);

      // beat 127 without in_last (continues the load just requested)
      run_frame(-1, 0, -1);
      repeat (3) tick();
      chk("t4_err", bus.err, 1);
      chk("t4_nstart", n_start, 0);
      chk("t4_busy", bus.busy, 0);

      // stale done high across START; load_req in WAIT_DONE ignored
      bus.done = 1'b1;
      tick();
      clear_logs();
      pulse_load();
      run_frame(127, 0, -1);
      repeat (5) tick();
      chk("t5_nstart", n_start, 1);
      chk("t5_nocomp", n_comp, 0);
      pulse_load();
      tick();
      chk("t5_busy_hold", bus.busy, 1);
      bus.done = 1'b0;
      tick();
      chk("t5_nocomp2", n_comp, 0);
      bus.done = 1'b1;
      tick(); tick();
      chk("t5_ncomp", n_comp, 1);
      chk("t5_idle", bus.busy, 0);
      bus.done = 1'b0;
      tick();

      // reset at beat 70, then a clean load
      clear_logs();
      pulse_load();
      run_frame(127, 0, 70);
      tick();
      chk("t6_post_rst_busy", bus.busy, 0);
      clear_logs();
      pulse_load();
      run_frame(127, 0, -1);
      tick(); tick();
      chk("t6_nwrA", n_wra, 64);
      chk("t6_nwrB", n_wrb, 64);
      chk("t6_nstart", n_start, 1);
      bus.done = 1'b1;
      tick(); tick();
      chk("t6_ncomp", n_comp, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
